// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-N up/down counter with load, sync clear, wrap/saturate,
// cascade terminal count, wrap pulse and sticky overflow.
module mod_updown_counter #(
   parameter int WIDTH       = 8,
   parameter int MODULUS     = 256,
   parameter int RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             sclr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_dn,
   input  logic             sat,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap_pulse,
   output logic             ovf
);
   // Limits are compared one bit wider so MODULUS == 2**WIDTH needs no special case
   localparam logic [WIDTH:0]   MAXV = (WIDTH+1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAXW = MAXV[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RSTV = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             wrap_q, wrap_d;
   logic             ovf_q, ovf_d;
   logic             at_max, at_zero, at_limit;

   assign at_max   = {1'b0, cnt_q} == MAXV;
   assign at_zero  = cnt_q == '0;
   assign at_limit = up_dn ? at_max : at_zero;

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      ovf_d  = ovf_q;
      if (sclr) begin
         cnt_d = RSTV;
         ovf_d = 1'b0;
      end else if (load) begin
         cnt_d = ({1'b0, load_val} > MAXV) ? MAXW : load_val;
      end else if (en) begin
         if (!at_limit) cnt_d = up_dn ? cnt_q + 1'b1 : cnt_q - 1'b1;
         else begin
            ovf_d  = 1'b1;
            wrap_d = ~sat;
            cnt_d  = sat ? cnt_q : (up_dn ? '0 : MAXW);
         end
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         cnt_q  <= RSTV;
         wrap_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
         ovf_q  <= ovf_d;
      end
   end

   assign q          = cnt_q;
   assign tc         = en & ~sclr & ~load & at_limit;
   assign wrap_pulse = wrap_q;
   assign ovf        = ovf_q;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed checks of a mod-10 counter plus a two-stage mod-16 cascade.
module tb_mod_updown_counter;
   logic       clk = 1'b0;
   logic       clear_n = 1'b0, sclr = 1'b0, load = 1'b0, en = 1'b0, up_dn = 1'b1, sat = 1'b0;
   logic [3:0] load_val = 4'd0;
   logic [3:0] q;
   logic       tc, wp, ovf;
   logic       rst_c = 1'b0, cen = 1'b0;
   logic [3:0] q0, q1;
   logic       tc0, tc1, wp0, wp1, ovf0, ovf1;
   int         total = 0, bad = 0;

   always #5 clk = ~clk;

   mod_updown_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u (
      .clk(clk), .clear_n(clear_n), .sclr(sclr), .load(load), .load_val(load_val),
      .en(en), .up_dn(up_dn), .sat(sat), .q(q), .tc(tc), .wrap_pulse(wp), .ovf(ovf));

   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) c0 (
      .clk(clk), .clear_n(rst_c), .sclr(1'b0), .load(1'b0), .load_val(4'd0),
      .en(cen), .up_dn(1'b1), .sat(1'b0), .q(q0), .tc(tc0), .wrap_pulse(wp0), .ovf(ovf0));

   mod_updown_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) c1 (
      .clk(clk), .clear_n(rst_c), .sclr(1'b0), .load(1'b0), .load_val(4'd0),
      .en(tc0), .up_dn(1'b1), .sat(1'b0), .q(q1), .tc(tc1), .wrap_pulse(wp1), .ovf(ovf1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int dn_q[4]  = '{1, 0, 9, 8};
      int sat_q[4] = '{8, 9, 9, 9};
      int sat_o[4] = '{0, 0, 1, 1};
      #12;
      chk("rst_q", q, 0);
      chk("rst_wp", wp, 0);
      chk("rst_ovf", ovf, 0);
      @(negedge clk);
      clear_n = 1'b1;
      rst_c   = 1'b1;
      en      = 1'b1;
      #1;
      for (int i = 1; i <= 12; i++) begin
         chk("up_tc", tc, (i == 10) ? 1 : 0);
         tick();
         chk("up_q", q, i % 10);
         chk("up_wp", wp, (i == 10) ? 1 : 0);
         chk("up_ovf", ovf, (i >= 10) ? 1 : 0);
      end
      en   = 1'b0;
      sclr = 1'b1;
      tick();
      chk("sclr_q", q, 0);
      chk("sclr_ovf", ovf, 0);
      sclr     = 1'b0;
      load     = 1'b1;
      load_val = 4'd2;
      tick();
      chk("ld_q", q, 2);
      load  = 1'b0;
      en    = 1'b1;
      up_dn = 1'b0;
      #1;
      chk("dn_tc0", tc, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("dn_q", q, dn_q[i]);
         chk("dn_wp", wp, (i == 2) ? 1 : 0);
         chk("dn_ovf", ovf, (i >= 2) ? 1 : 0);
         chk("dn_tc", tc, (dn_q[i] == 0) ? 1 : 0);
      end
      en   = 1'b0;
      sclr = 1'b1;
      tick();
      chk("sclr2_ovf", ovf, 0);
      sclr     = 1'b0;
      load     = 1'b1;
      load_val = 4'd7;
      tick();
      chk("ld7_q", q, 7);
      load  = 1'b0;
      en    = 1'b1;
      up_dn = 1'b1;
      sat   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("sat_q", q, sat_q[i]);
         chk("sat_ovf", ovf, sat_o[i]);
         chk("sat_wp", wp, 0);
         chk("sat_tc", tc, (sat_q[i] == 9) ? 1 : 0);
      end
      up_dn = 1'b0;
      tick();
      chk("satdn_q8", q, 8);
      tick();
      chk("satdn_q7", q, 7);
      chk("satdn_ovf", ovf, 1);
      en       = 1'b0;
      sat      = 1'b0;
      load     = 1'b1;
      load_val = 4'd15;
      tick();
      chk("clamp_q", q, 9);
      sclr = 1'b1;
      en   = 1'b1;
      tick();
      chk("prio_sclr_q", q, 0);
      chk("prio_sclr_ovf", ovf, 0);
      sclr     = 1'b0;
      load_val = 4'd5;
      #1;
      chk("ld_blocks_tc", tc, 0);
      tick();
      chk("prio_ld_q", q, 5);
      en       = 1'b0;
      up_dn    = 1'b1;
      load_val = 4'd9;
      tick();
      chk("ld9_q", q, 9);
      load = 1'b0;
      en   = 1'b1;
      tick();
      chk("wrap_q", q, 0);
      chk("wrap_wp", wp, 1);
      chk("wrap_ovf", ovf, 1);
      repeat (6) tick();
      chk("pre_async_q", q, 6);
      en = 1'b0;
      #2;
      clear_n = 1'b0;
      #1;
      chk("async_q", q, 0);
      chk("async_ovf", ovf, 0);
      @(negedge clk);
      clear_n = 1'b1;
      en      = 1'b1;
      tick();
      chk("post_async_q", q, 1);
      en   = 1'b0;
      load = 1'b1;
      tick();
      load = 1'b0;
      en   = 1'b1;
      tick();
      chk("pend_wp", wp, 1);
      #2;
      clear_n = 1'b0;
      #1;
      chk("drop_wp", wp, 0);
      chk("drop_q", q, 0);
      @(negedge clk);
      clear_n = 1'b1;
      en      = 1'b0;
      chk("casc_init", {q1, q0}, 0);
      cen = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         chk("casc_cnt", {q1, q0}, i);
      end
      chk("casc_ovf0", ovf0, 1);
      chk("casc_ovf1", ovf1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
